vdf_square_sequencer: RTL

//  Runs one VDF evaluation on the modular squaring wrapper: accepts (x, T), clears and launches the

---
 rtl/vdf_seq_pkg.sv | 36 +++
 rtl/vdf_watchdog_timer.sv | 31 +++
 rtl/vdf_square_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vdf_seq_pkg.sv
// Shared types, widths and the coefficient packing helper for the VDF squaring sequencer.
package vdf_seq_pkg;

    localparam int MOD_LEN      = 1024;
    localparam int WORD_LEN     = 16;
    localparam int SLOT_W       = 2 * WORD_LEN;
    localparam int NUM_ELEMENTS = MOD_LEN / WORD_LEN;
    localparam int SQ_OUT_BITS  = NUM_ELEMENTS * SLOT_W;
    localparam int ITER_W       = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        RESULT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_ABORT   = 2'd1,
        ST_TIMEOUT = 2'd2
    } status_t;

    // Spreads each WORD_LEN coefficient of x into a zero-extended SLOT_W slot,
    // matching the squarer's output format.
    function automatic logic [SQ_OUT_BITS-1:0] pack_coeffs(input logic [MOD_LEN-1:0] x);
        logic [SQ_OUT_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            r[i*SLOT_W +: SLOT_W] = {{(SLOT_W-WORD_LEN){1'b0}}, x[i*WORD_LEN +: WORD_LEN]};
        end
        return r;
    endfunction

endpackage

// File: rtl/vdf_watchdog_timer.sv
// Stall watchdog: counts enabled cycles since the last load and flags expiry.
module vdf_watchdog_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i || load_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A load in the same cycle always wins over expiry.
    assign expired_o = en_i && !load_i && (cnt_q == LAST);

endmodule

// File: rtl/vdf_square_sequencer.sv
// Drives one VDF evaluation on the modular squarer: clear, launch, count T results,
// then hand the final value (or abort/timeout snapshot) to the host on a ready/valid port.
module vdf_square_sequencer
    import vdf_seq_pkg::*;
#(
    parameter int CLEAR_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [MOD_LEN-1:0]     cmd_x_i,
    input  logic [ITER_W-1:0]      cmd_iters_i,
    input  logic                   cmd_abort_i,
    output logic                   msq_reset_o,
    output logic                   msq_start_o,
    output logic [MOD_LEN-1:0]     msq_sq_in_o,
    input  logic [SQ_OUT_BITS-1:0] msq_sq_out_i,
    input  logic                   msq_valid_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [SQ_OUT_BITS-1:0] res_data_o,
    output logic [ITER_W-1:0]      res_iters_o,
    output logic [1:0]             res_status_o,
    output logic                   busy_o,
    output logic [ITER_W-1:0]      iter_count_o,
    output logic [2:0]             state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; res_* stay
    // stable while res_valid is high and res_ready is low; cmd_ready is high only in IDLE.

    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

    state_t                 state_q;
    logic                   cmd_ready_q;
    logic                   msq_reset_q;
    logic                   msq_start_q;
    logic [MOD_LEN-1:0]     msq_sq_in_q;
    logic                   res_valid_q;
    logic [SQ_OUT_BITS-1:0] res_data_q;
    logic [ITER_W-1:0]      res_iters_q;
    status_t                res_status_q;
    logic                   busy_q;
    logic [ITER_W-1:0]      iter_count_q;
    logic [MOD_LEN-1:0]     x_q;
    logic [ITER_W-1:0]      iters_q;
    logic [SQ_OUT_BITS-1:0] last_q;
    logic [CLR_W-1:0]       clr_cnt_q;

    logic                   wd_clear;
    logic                   wd_load;
    logic                   wd_en;
    logic                   wd_expired;

    logic [ITER_W-1:0]      iter_inc_d;
    logic                   finish_d;
    status_t                fin_status_d;
    logic [ITER_W-1:0]      fin_iters_d;
    logic [SQ_OUT_BITS-1:0] fin_data_d;

    assign wd_clear = (state_q != LAUNCH) && (state_q != RUN);
    assign wd_load  = (state_q == LAUNCH) || ((state_q == RUN) && msq_valid_i);
    assign wd_en    = (state_q == RUN);

    vdf_watchdog_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (wd_clear),
        .load_i   (wd_load),
        .en_i     (wd_en),
        .expired_o(wd_expired)
    );

    // Run termination: final valid beats abort beats timeout; a non-final valid in the
    // abort cycle is still counted and captured.
    always_comb begin
        iter_inc_d   = iter_count_q + 1'b1;
        finish_d     = 1'b0;
        fin_status_d = ST_OK;
        fin_iters_d  = iter_count_q;
        fin_data_d   = last_q;
        case (state_q)
            CLEAR, LAUNCH: begin
                if (cmd_abort_i) begin
                    finish_d     = 1'b1;
                    fin_status_d = ST_ABORT;
                end
            end
            RUN: begin
                if (msq_valid_i && (iter_inc_d == iters_q)) begin
                    finish_d    = 1'b1;
                    fin_iters_d = iter_inc_d;
                    fin_data_d  = msq_sq_out_i;
                end else if (cmd_abort_i) begin
                    finish_d     = 1'b1;
                    fin_status_d = ST_ABORT;
                    if (msq_valid_i) begin
                        fin_iters_d = iter_inc_d;
                        fin_data_d  = msq_sq_out_i;
                    end
                end else if (wd_expired) begin
                    finish_d     = 1'b1;
                    fin_status_d = ST_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b0;
            msq_reset_q  <= 1'b1;
            msq_start_q  <= 1'b0;
            msq_sq_in_q  <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_iters_q  <= '0;
            res_status_q <= ST_OK;
            busy_q       <= 1'b0;
            iter_count_q <= '0;
            x_q          <= '0;
            iters_q      <= '0;
            last_q       <= '0;
            clr_cnt_q    <= '0;
        end else if (finish_d) begin
            state_q      <= RESULT;
            msq_reset_q  <= 1'b1;
            msq_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b1;
            res_status_q <= fin_status_d;
            res_iters_q  <= fin_iters_d;
            res_data_q   <= fin_data_d;
            iter_count_q <= fin_iters_d;
        end else begin
            case (state_q)
                IDLE: begin
                    msq_reset_q <= 1'b1;
                    if (cmd_ready_q && cmd_valid_i) begin
                        cmd_ready_q  <= 1'b0;
                        x_q          <= cmd_x_i;
                        iters_q      <= cmd_iters_i;
                        iter_count_q <= '0;
                        last_q       <= '0;
                        clr_cnt_q    <= '0;
                        if (cmd_iters_i == '0) begin
                            state_q      <= RESULT;
                            res_valid_q  <= 1'b1;
                            res_data_q   <= pack_coeffs(cmd_x_i);
                            res_iters_q  <= '0;
                            res_status_q <= ST_OK;
                        end else begin
                            state_q <= CLEAR;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q     <= LAUNCH;
                        msq_reset_q <= 1'b0;
                        msq_start_q <= 1'b1;
                        msq_sq_in_q <= x_q;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                LAUNCH: begin
                    state_q     <= RUN;
                    msq_start_q <= 1'b0;
                end
                RUN: begin
                    if (msq_valid_i) begin
                        iter_count_q <= iter_inc_d;
                        last_q       <= msq_sq_out_i;
                    end
                end
                RESULT: begin
                    msq_reset_q <= 1'b1;
                    if (res_ready_i) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign msq_reset_o  = msq_reset_q;
    assign msq_start_o  = msq_start_q;
    assign msq_sq_in_o  = msq_sq_in_q;
    assign res_valid_o  = res_valid_q;
    assign res_data_o   = res_data_q;
    assign res_iters_o  = res_iters_q;
    assign res_status_o = res_status_q;
    assign busy_o       = busy_q;
    assign iter_count_o = iter_count_q;
    assign state_o      = state_q;

endmodule
